// File: rtl/tlight_phase_sched_pkg.sv
// Shared phase-kind/axis codes and the {axis, kind} phase encoding for the light scheduler.
package tlight_phase_sched_pkg;

  typedef enum logic [1:0] {
    PH_CLR = 2'd0,
    PH_G   = 2'd1,
    PH_L   = 2'd2,
    PH_Y   = 2'd3
  } kind_e;

  localparam logic AX_EW = 1'b0;
  localparam logic AX_NS = 1'b1;

  // Encoding is the phase output code itself: {axis, kind}
  typedef enum logic [2:0] {
    EW_CLR = 3'b000,
    EW_G   = 3'b001,
    EW_L   = 3'b010,
    EW_Y   = 3'b011,
    NS_CLR = 3'b100,
    NS_G   = 3'b101,
    NS_L   = 3'b110,
    NS_Y   = 3'b111
  } phase_e;

  function automatic phase_e mk_phase(input logic axis, input kind_e kind);
    return phase_e'({axis, kind});
  endfunction

endpackage

// File: rtl/tlight_phase_sched_if.sv
// Request/phase bus between the intersection controller and the phase scheduler.
// Preempt signals exist only when TLIGHT_PREEMPT_EN is defined.
interface tlight_phase_sched_if #(
  parameter int TW = 5
);
  logic          tick;
  logic          ped_req_ew;
  logic          ped_req_ns;
  logic          left_req_ew;
  logic          left_req_ns;
`ifdef TLIGHT_PREEMPT_EN
  logic          preempt;
  logic          preempt_axis;
`endif
  logic [2:0]    phase;
  logic          walk_ew;
  logic          walk_ns;
  logic          ped_flash;
  logic          ped_ack_ew;
  logic          ped_ack_ns;
  logic          phase_start;
  logic [TW-1:0] remain;

  modport master (
    output tick, ped_req_ew, ped_req_ns, left_req_ew, left_req_ns,
`ifdef TLIGHT_PREEMPT_EN
    output preempt, preempt_axis,
`endif
    input  phase, walk_ew, walk_ns, ped_flash, ped_ack_ew, ped_ack_ns,
    input  phase_start, remain
  );

  modport slave (
    input  tick, ped_req_ew, ped_req_ns, left_req_ew, left_req_ns,
`ifdef TLIGHT_PREEMPT_EN
    input  preempt, preempt_axis,
`endif
    output phase, walk_ew, walk_ns, ped_flash, ped_ack_ew, ped_ack_ns,
    output phase_start, remain
  );

endinterface

// File: rtl/tlight_phase_sched_tick_timer.sv
// Loadable down counter stepped by the tick strobe; done fires on a tick at zero unless held.
module tlight_tick_timer #(
  parameter int            TW      = 5,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          hold,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] remain,
  output logic          done
);

  assign done = tick && !hold && (remain == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      remain <= RST_VAL;
    end else if (load) begin
      remain <= load_val;
    end else if (tick && !hold && (remain != '0)) begin
      remain <= remain - 1'b1;
    end
  end

endmodule

// File: rtl/tlight_phase_sched.sv
// Intersection phase scheduler: G -> [L] -> Y -> CLR per axis, ped walk service, tick timing.
// Optional emergency preempt support is compiled in with TLIGHT_PREEMPT_EN.
module tlight_phase_sched
  import tlight_phase_sched_pkg::*;
#(
  parameter int GREEN_T = 22,
  parameter int LEFT_T  = 8,
  parameter int YEL_T   = 3,
  parameter int CLR_T   = 2,
  parameter int FLASH_T = 7,
  parameter int TW      = 5
) (
  input logic                clk,
  input logic                reset,
  tlight_phase_sched_if.slave bus
);

  localparam logic [TW-1:0] G_LD   = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] L_LD   = TW'(LEFT_T - 1);
  localparam logic [TW-1:0] Y_LD   = TW'(YEL_T - 1);
  localparam logic [TW-1:0] C_LD   = TW'(CLR_T - 1);
  localparam logic [TW-1:0] FL_LIM = TW'(FLASH_T);

  phase_e        state, state_nx;
  logic          cur_axis, nx_axis;
  kind_e         cur_kind, nx_kind;
  logic          pre_act, pre_axis;
  logic          trip, hold, done, adv;
  logic [TW-1:0] remain, load_val;
  logic [1:0]    ped_req, left_req, ped_lat, left_lat;
  logic [1:0]    ped_srv, left_clr, walk_q, ack_q, walk_o;
  logic          start_q;

`ifdef TLIGHT_PREEMPT_EN
  assign pre_act  = bus.preempt;
  assign pre_axis = bus.preempt_axis;
`else
  assign pre_act  = 1'b0;
  assign pre_axis = AX_EW;
`endif

  assign cur_axis = state[2];
  assign cur_kind = kind_e'(state[1:0]);
  assign ped_req  = {bus.ped_req_ns, bus.ped_req_ew};
  assign left_req = {bus.left_req_ns, bus.left_req_ew};

  // Preempt cuts the crossing axis short to yellow; the preempt axis parks in green.
  assign trip = pre_act && (cur_kind == PH_G || cur_kind == PH_L) && (cur_axis != pre_axis);
  assign hold = pre_act && (cur_kind == PH_G) && (cur_axis == pre_axis);
  assign adv  = trip || done;

  tlight_tick_timer #(
    .TW      (TW),
    .RST_VAL (C_LD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (bus.tick),
    .hold     (hold),
    .load     (adv),
    .load_val (load_val),
    .remain   (remain),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NS_CLR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (trip) begin
      state_nx = mk_phase(cur_axis, PH_Y);
    end else if (done) begin
      case (cur_kind)
        PH_G:    state_nx = mk_phase(cur_axis, left_lat[cur_axis] ? PH_L : PH_Y);
        PH_L:    state_nx = mk_phase(cur_axis, PH_Y);
        PH_Y:    state_nx = mk_phase(cur_axis, PH_CLR);
        default: state_nx = mk_phase(~cur_axis, PH_G);
      endcase
    end
  end

  always_comb begin
    nx_axis  = state_nx[2];
    nx_kind  = kind_e'(state_nx[1:0]);
    ped_srv  = '0;
    left_clr = '0;
    if (adv && nx_kind == PH_G) ped_srv[nx_axis]  = ped_lat[nx_axis];
    if (adv && nx_kind == PH_L) left_clr[nx_axis] = 1'b1;
    case (nx_kind)
      PH_G:    load_val = G_LD;
      PH_L:    load_val = L_LD;
      PH_Y:    load_val = Y_LD;
      default: load_val = C_LD;
    endcase
    walk_o = walk_q & {2{~pre_act}};
  end

  // Set-wins latches; walk is captured on every phase change, so it only survives into G.
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_lat  <= '0;
      left_lat <= '0;
      walk_q   <= '0;
      ack_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      ped_lat  <= ped_req | (ped_lat & ~ped_srv);
      left_lat <= left_req | (left_lat & ~left_clr);
      ack_q    <= ped_srv;
      start_q  <= adv;
      if (adv) walk_q <= ped_srv;
    end
  end

  assign bus.phase       = state;
  assign bus.remain      = remain;
  assign bus.walk_ew     = walk_o[0];
  assign bus.walk_ns     = walk_o[1];
  assign bus.ped_flash   = (|walk_o) && (remain < FL_LIM);
  assign bus.ped_ack_ew  = ack_q[0];
  assign bus.ped_ack_ns  = ack_q[1];
  assign bus.phase_start = start_q;

endmodule

// File: tb/tb_tlight_phase_sched.sv
// Bench for tlight_phase_sched: directed table, corner sequences, random run vs. phase-level model.
module tb_tlight_phase_sched;

  localparam int GREEN_T = 6;
  localparam int LEFT_T  = 3;
  localparam int YEL_T   = 2;
  localparam int CLR_T   = 1;
  localparam int FLASH_T = 2;
  localparam int TW      = 5;
`ifdef TLIGHT_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  typedef struct packed {
    logic rst, tick, ped_ew, ped_ns, left_ew, left_ns, pre, pax;
  } drv_t;

  typedef struct packed {
    logic       tick;
    logic [2:0] ph;
    logic [4:0] rem;
    logic       ps;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlight_phase_sched_if #(.TW(TW)) bus ();

  tlight_phase_sched #(
    .GREEN_T (GREEN_T),
    .LEFT_T  (LEFT_T),
    .YEL_T   (YEL_T),
    .CLR_T   (CLR_T),
    .FLASH_T (FLASH_T),
    .TW      (TW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  drv_t drv;

  // Reference model: which axis/kind is lit, ticks elapsed in it, and pending requests.
  int       dur [4];
  int       m_axis, m_kind, m_el;
  bit [1:0] m_ped, m_left, m_ack;
  bit       m_walk, m_ps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input drv_t d);
    bit trip, hold, ended, adv, served;
    if (d.rst) begin
      m_axis = 1; m_kind = 0; m_el = 0;
      m_ped = '0; m_left = '0; m_ack = '0; m_walk = 0; m_ps = 0;
      return;
    end
    trip   = PRE && d.pre && (m_kind == 1 || m_kind == 2) && (m_axis != int'(d.pax));
    hold   = PRE && d.pre && (m_kind == 1) && (m_axis == int'(d.pax));
    ended  = d.tick && !hold && (m_el == dur[m_kind] - 1);
    adv    = trip || ended;
    served = 0;
    m_ack  = '0;
    if (trip) begin
      m_kind = 3;
    end else if (ended) begin
      case (m_kind)
        1: if (m_left[m_axis]) begin m_kind = 2; m_left[m_axis] = 0; end else m_kind = 3;
        2: m_kind = 3;
        3: m_kind = 0;
        default: begin
          m_axis = 1 - m_axis;
          m_kind = 1;
          if (m_ped[m_axis]) begin
            served = 1; m_ped[m_axis] = 0; m_ack[m_axis] = 1;
          end
        end
      endcase
    end else if (d.tick && !hold) begin
      m_el++;
    end
    if (adv) begin
      m_el   = 0;
      m_walk = served;
    end
    m_ps   = adv;
    m_ped  = m_ped | {d.ped_ns, d.ped_ew};
    m_left = m_left | {d.left_ns, d.left_ew};
  endtask

  function automatic logic [13:0] model_out(input drv_t d);
    int rem;
    bit wew, wns, fl;
    rem = dur[m_kind] - 1 - m_el;
    wew = m_walk && m_axis == 0 && !(PRE && d.pre);
    wns = m_walk && m_axis == 1 && !(PRE && d.pre);
    fl  = (wew || wns) && rem < FLASH_T;
    return {3'(m_axis * 4 + m_kind), 5'(rem), wew, wns, fl, m_ack[0], m_ack[1], m_ps};
  endfunction

  function automatic logic [13:0] dut_out();
    return {bus.phase, bus.remain, bus.walk_ew, bus.walk_ns, bus.ped_flash,
            bus.ped_ack_ew, bus.ped_ack_ns, bus.phase_start};
  endfunction

  task automatic step();
    reset           = drv.rst;
    bus.tick        = drv.tick;
    bus.ped_req_ew  = drv.ped_ew;
    bus.ped_req_ns  = drv.ped_ns;
    bus.left_req_ew = drv.left_ew;
    bus.left_req_ns = drv.left_ns;
`ifdef TLIGHT_PREEMPT_EN
    bus.preempt      = drv.pre;
    bus.preempt_axis = drv.pax;
`endif
    @(posedge clk);
    model_edge(drv);
    #1;
    check("model", 32'(dut_out()), 32'(model_out(drv)));
  endtask

  task automatic do_reset();
    drv = '0;
    drv.rst = 1'b1;
    repeat (3) step();
    check("reset_state", 32'(dut_out()), 32'({3'd4, 5'd0, 6'b0}));
    drv.rst = 1'b0;
    drv.tick = 1'b1;
  endtask

  task automatic goto_phase(input int p);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_ps && (m_axis * 4 + m_kind) == p) && n < 100);
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL goto_phase: phase %0d not reached, got %0d required %0d", p, bus.phase, p);
    end
  endtask

  task automatic chk_ph(input string name, input logic [2:0] ph, input logic [4:0] rem);
    check(name, 32'({bus.phase, bus.remain}), 32'({ph, rem}));
  endtask

  vec_t tbl [21];

  initial begin
    dur = '{CLR_T, GREEN_T, LEFT_T, YEL_T};
    tbl = '{
      '{1'b1, 3'd1, 5'd5, 1'b1}, '{1'b1, 3'd1, 5'd4, 1'b0}, '{1'b1, 3'd1, 5'd3, 1'b0},
      '{1'b0, 3'd1, 5'd3, 1'b0}, '{1'b1, 3'd1, 5'd2, 1'b0}, '{1'b1, 3'd1, 5'd1, 1'b0},
      '{1'b1, 3'd1, 5'd0, 1'b0}, '{1'b1, 3'd3, 5'd1, 1'b1}, '{1'b1, 3'd3, 5'd0, 1'b0},
      '{1'b1, 3'd0, 5'd0, 1'b1}, '{1'b1, 3'd5, 5'd5, 1'b1}, '{1'b1, 3'd5, 5'd4, 1'b0},
      '{1'b1, 3'd5, 5'd3, 1'b0}, '{1'b1, 3'd5, 5'd2, 1'b0}, '{1'b1, 3'd5, 5'd1, 1'b0},
      '{1'b1, 3'd5, 5'd0, 1'b0}, '{1'b1, 3'd7, 5'd1, 1'b1}, '{1'b0, 3'd7, 5'd1, 1'b0},
      '{1'b1, 3'd7, 5'd0, 1'b0}, '{1'b1, 3'd4, 5'd0, 1'b1}, '{1'b1, 3'd1, 5'd5, 1'b1}
    };

    // Plain cycle, no requests
    do_reset();
    for (int i = 0; i < 21; i++) begin
      drv.tick = tbl[i].tick;
      step();
      check($sformatf("tbl_%0d", i),
            32'({bus.phase, bus.remain, bus.phase_start, bus.walk_ew, bus.walk_ns}),
            32'({tbl[i].ph, tbl[i].rem, tbl[i].ps, 2'b00}));
    end
    drv.tick = 1'b1;

    // Left-turn insertion, then skipped on the following EW cycle
    do_reset();
    goto_phase(1);
    drv.left_ew = 1'b1; step(); drv.left_ew = 1'b0;
    repeat (4) step();
    chk_ph("t2_g_end", 3'd1, 5'd0);
    step();
    chk_ph("t2_l_entry", 3'd2, 5'd2);
    repeat (3) step();
    chk_ph("t2_y_entry", 3'd3, 5'd1);
    goto_phase(1);
    repeat (6) step();
    chk_ph("t2_skip_l", 3'd3, 5'd1);

    // NS ped service with flash window
    do_reset();
    goto_phase(1);
    drv.ped_ns = 1'b1; step(); drv.ped_ns = 1'b0;
    goto_phase(5);
    check("t3_entry", 32'({bus.ped_ack_ns, bus.walk_ns, bus.walk_ew, bus.ped_flash}), 32'(4'b1100));
    step();
    check("t3_ack_pulse", 32'({bus.ped_ack_ns, bus.walk_ns}), 32'(2'b01));
    repeat (2) step();
    check("t3_noflash", 32'({bus.remain, bus.walk_ns, bus.ped_flash}), 32'({5'd2, 2'b10}));
    step();
    check("t3_flash", 32'({bus.remain, bus.walk_ns, bus.ped_flash}), 32'({5'd1, 2'b11}));
    repeat (2) step();
    check("t3_walk_drop", 32'({bus.phase, bus.walk_ns, bus.ped_flash}), 32'({3'd7, 2'b00}));
    goto_phase(5);
    check("t3_latch_clr", 32'(bus.walk_ns), 32'(0));

    // Held EW button: served now and re-latched for the next EW green
    do_reset();
    goto_phase(5);
    drv.ped_ew = 1'b1;
    goto_phase(1);
    check("t4_served", 32'({bus.ped_ack_ew, bus.walk_ew}), 32'(2'b11));
    repeat (5) step();
    check("t4_walk_held", 32'({bus.phase, bus.remain, bus.walk_ew}), 32'({3'd1, 5'd0, 1'b1}));
    drv.ped_ew = 1'b0;
    goto_phase(1);
    check("t4_relatched", 32'({bus.ped_ack_ew, bus.walk_ew}), 32'(2'b11));
    goto_phase(1);
    check("t4_done", 32'(bus.walk_ew), 32'(0));

    // Reset in the middle of NS left clears everything
    do_reset();
    drv.left_ns = 1'b1; step(); drv.left_ns = 1'b0;
    goto_phase(6);
    drv.left_ew = 1'b1; drv.ped_ew = 1'b1; step();
    drv.left_ew = 1'b0; drv.ped_ew = 1'b0;
    drv.rst = 1'b1; step();
    check("t5_reset", 32'(dut_out()), 32'({3'd4, 5'd0, 6'b0}));
    drv.rst = 1'b0;
    goto_phase(1);
    check("t5_ped_clr", 32'(bus.walk_ew), 32'(0));
    repeat (6) step();
    chk_ph("t5_left_clr", 3'd3, 5'd1);

`ifdef TLIGHT_PREEMPT_EN
    // Preempt toward NS from EW green
    do_reset();
    goto_phase(1);
    drv.ped_ns = 1'b1; step(); drv.ped_ns = 1'b0;
    drv.pre = 1'b1; drv.pax = 1'b1; step();
    chk_ph("t6_trip", 3'd3, 5'd1);
    repeat (2) step();
    chk_ph("t6_clr", 3'd0, 5'd0);
    step();
    chk_ph("t6_ns_g", 3'd5, 5'd5);
    repeat (10) step();
    check("t6_hold", 32'({bus.phase, bus.remain, bus.walk_ns}), 32'({3'd5, 5'd5, 1'b0}));
    drv.pre = 1'b0;
    repeat (5) step();
    check("t6_resume", 32'({bus.phase, bus.remain, bus.walk_ns}), 32'({3'd5, 5'd0, 1'b1}));
    step();
    chk_ph("t6_y", 3'd7, 5'd1);
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drv.rst     = ($urandom_range(0, 499) == 0);
      drv.tick    = ($urandom_range(0, 3) != 0);
      drv.ped_ew  = ($urandom_range(0, 19) == 0);
      drv.ped_ns  = ($urandom_range(0, 19) == 0);
      drv.left_ew = ($urandom_range(0, 19) == 0);
      drv.left_ns = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0) begin
        drv.pre = ~drv.pre;
        drv.pax = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
